// File: rtl/seq_pkg.sv
// Shared constants for the task sequencer: word width, status location and FSM encoding.
// The optional per-task timeout is enabled with the TASK_TIMEOUT_EN macro.
package seq_pkg;

  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] STATUS_ADDR = 16'h0004;
  localparam int STATUS_TIMEOUT_BIT = 15;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SCAN   = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_LAUNCH = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_WRSTAT = 3'd5;
  localparam logic [2:0] ST_FIN    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SCAN   = ST_SCAN,
    S_CLEAR  = ST_CLEAR,
    S_LAUNCH = ST_LAUNCH,
    S_RUN    = ST_RUN,
    S_WRSTAT = ST_WRSTAT,
    S_FIN    = ST_FIN
  } state_t;

  // Width of a slot index; a single slot still needs one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Shared memory port select: the active task's port while running, otherwise the
// sequencer's own status source (address/data fixed, write only when requested).
module mem_port_mux #(
  parameter int NUM_TASKS  = 4,
  parameter int WORD_WIDTH = 16,
  parameter int SEL_W      = 2
) (
  input  logic                            run,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            status_wr,
  input  logic [WORD_WIDTH-1:0]           status_address,
  input  logic [WORD_WIDTH-1:0]           status_data,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_address,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_data_out,
  output logic [WORD_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_data_out
);
  import seq_pkg::*;

  always_comb begin
    mem_address  = status_address;
    mem_data_out = status_data;
    mem_wr_en    = status_wr;
    if (run) begin
      mem_address  = task_address[int'(sel)*WORD_WIDTH +: WORD_WIDTH];
      mem_data_out = task_data_out[int'(sel)*WORD_WIDTH +: WORD_WIDTH];
      mem_wr_en    = task_wr_en[sel];
    end
  end

endmodule

// File: rtl/task_sequencer_mem_arbiter.sv
// Runs enabled task slots in ascending order, owns the shared memory port and writes one
// packed status word per round. Optional per-task timeout: define TASK_TIMEOUT_EN.
module task_sequencer_mem_arbiter #(
  parameter int NUM_TASKS = 4,
  parameter int WORD_WIDTH = seq_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] STATUS_ADDR = seq_pkg::STATUS_ADDR
`ifdef TASK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_TASKS-1:0]            task_mask,
  output logic [NUM_TASKS-1:0]            task_clear,
  output logic [NUM_TASKS-1:0]            task_start,
  input  logic [NUM_TASKS-1:0]            task_done,
  input  logic [NUM_TASKS-1:0]            task_flag,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_address,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_data_out,
  output logic [WORD_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_data_out,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_TASKS-1:0]            flags,
  output logic [2:0]                      state_dbg
`ifdef TASK_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);
  import seq_pkg::*;

  localparam int KW = $clog2(NUM_TASKS + 1);
  localparam int IW = index_width(NUM_TASKS);

  // Handshake: start is accepted only in IDLE (busy=0) and ignored otherwise; done is a
  // one-cycle pulse, coincident with busy falling, after the single status write.
  state_t                 state;
  logic [NUM_TASKS-1:0]   mask_q;
  logic [NUM_TASKS-1:0]   flags_q;
  logic [KW-1:0]          k;
  logic [IW-1:0]          k_idx;
  logic                   busy_q;
  logic                   done_q;
  logic                   scan_found;
  logic [KW-1:0]          scan_slot;
  logic [NUM_TASKS-1:0]   onehot_k;
  logic [WORD_WIDTH-1:0]  status_word;
  logic                   in_run;
  logic                   in_wrstat;
`ifdef TASK_TIMEOUT_EN
  logic                   timeout_any;
  logic [15:0]            to_cnt;
`endif

  assign k_idx     = k[IW-1:0];
  assign onehot_k  = NUM_TASKS'(1) << k_idx;
  assign in_run    = (state == S_RUN);
  assign in_wrstat = (state == S_WRSTAT);

  // Descending walk so the lowest enabled slot at or above k wins.
  always_comb begin
    scan_found = 1'b0;
    scan_slot  = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (mask_q[i] && (KW'(i) >= k)) begin
        scan_found = 1'b1;
        scan_slot  = KW'(i);
      end
    end
  end

  always_comb begin
    status_word = '0;
    status_word[NUM_TASKS-1:0] = flags_q;
`ifdef TASK_TIMEOUT_EN
    status_word[STATUS_TIMEOUT_BIT] = timeout_any;
`endif
  end

  // Clear is forced while in reset so every slot comes back reinitialised.
  assign task_clear = rst ? '1 : ((state == S_CLEAR) ? onehot_k : '0);
  assign task_start = (state == S_LAUNCH) ? onehot_k : '0;

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= S_IDLE;
      mask_q  <= '0;
      flags_q <= '0;
      k       <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TASK_TIMEOUT_EN
      timeout_any <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q  <= task_mask;
            flags_q <= '0;
            k       <= '0;
            busy_q  <= 1'b1;
`ifdef TASK_TIMEOUT_EN
            timeout_any <= 1'b0;
`endif
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_found) begin
            k     <= scan_slot;
            state <= S_CLEAR;
          end else begin
            state <= S_WRSTAT;
          end
        end
        S_CLEAR: state <= S_LAUNCH;
        S_LAUNCH: begin
`ifdef TASK_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= S_RUN;
        end
        S_RUN: begin
          if (task_done[k_idx]) begin
            flags_q[k_idx] <= task_flag[k_idx];
            k              <= k + KW'(1);
            state          <= S_SCAN;
          end
`ifdef TASK_TIMEOUT_EN
          else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            flags_q[k_idx] <= 1'b0;
            timeout_any    <= 1'b1;
            k              <= k + KW'(1);
            state          <= S_SCAN;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        S_WRSTAT: state <= S_FIN;
        S_FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_port_mux #(
    .NUM_TASKS  (NUM_TASKS),
    .WORD_WIDTH (WORD_WIDTH),
    .SEL_W      (IW)
  ) u_mem_port_mux (
    .run            (in_run),
    .sel            (k_idx),
    .status_wr      (in_wrstat),
    .status_address (STATUS_ADDR),
    .status_data    (status_word),
    .task_address   (task_address),
    .task_wr_en     (task_wr_en),
    .task_data_out  (task_data_out),
    .mem_address    (mem_address),
    .mem_wr_en      (mem_wr_en),
    .mem_data_out   (mem_data_out)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign flags     = flags_q;
  assign state_dbg = state;
`ifdef TASK_TIMEOUT_EN
  assign timeout_err = timeout_any;
`endif

endmodule

// File: tb/tb_task_sequencer_mem_arbiter.sv
// Directed bench for task_sequencer_mem_arbiter: behavioural task slots, a status-write
// scoreboard and per-round latency/flag checks. Timeout rounds run when TASK_TIMEOUT_EN is set.
module tb_task_sequencer_mem_arbiter;

  localparam int NT = 4;
  localparam int W  = 16;
  localparam logic [W-1:0] ST_ADDR = 16'h0004;

  logic           clock;
  logic           rst;
  logic           start;
  logic [NT-1:0]  task_mask;
  logic [NT-1:0]  task_clear;
  logic [NT-1:0]  task_start;
  logic [NT-1:0]  task_done;
  logic [NT-1:0]  task_flag;
  logic [NT*W-1:0] task_address;
  logic [NT-1:0]  task_wr_en;
  logic [NT*W-1:0] task_data_out;
  logic [W-1:0]   mem_address;
  logic           mem_wr_en;
  logic [W-1:0]   mem_data_out;
  logic           busy;
  logic           done;
  logic [NT-1:0]  flags;
  logic [2:0]     state_dbg;
`ifdef TASK_TIMEOUT_EN
  logic           timeout_err;
`endif

  task_sequencer_mem_arbiter #(
    .NUM_TASKS (NT)
`ifdef TASK_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .start         (start),
    .task_mask     (task_mask),
    .task_clear    (task_clear),
    .task_start    (task_start),
    .task_done     (task_done),
    .task_flag     (task_flag),
    .task_address  (task_address),
    .task_wr_en    (task_wr_en),
    .task_data_out (task_data_out),
    .mem_address   (mem_address),
    .mem_wr_en     (mem_wr_en),
    .mem_data_out  (mem_data_out),
    .busy          (busy),
    .done          (done),
    .flags         (flags),
    .state_dbg     (state_dbg)
`ifdef TASK_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural task slots ----------------
  int            lat_cfg[NT];
  logic [NT-1:0] flag_cfg;
  logic [NT-1:0] wr_cfg;
  logic [NT-1:0] m_run;
  logic [NT-1:0] m_done;
  int            m_cnt[NT];
  logic [W-1:0]  slot_addr[NT];
  logic [W-1:0]  slot_data[NT];

  initial begin
    slot_addr[0] = 16'h0010; slot_addr[1] = 16'h0002;
    slot_addr[2] = 16'h0012; slot_addr[3] = 16'h0013;
    slot_data[0] = 16'hA000; slot_data[1] = 16'hBEEF;
    slot_data[2] = 16'hA002; slot_data[3] = 16'hA003;
  end

  // A slot with latency 0 never finishes (models a hung task).
  always @(posedge clock) begin
    for (int i = 0; i < NT; i++) begin
      if (task_clear[i]) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
      end else if (task_start[i]) begin
        m_run[i] <= (lat_cfg[i] > 0);
        m_cnt[i] <= lat_cfg[i];
      end else if (m_run[i]) begin
        if (m_cnt[i] <= 1) begin
          m_done[i] <= 1'b1;
          m_run[i]  <= 1'b0;
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
    end
  end

  assign task_done     = m_done;
  assign task_flag     = flag_cfg;
  assign task_wr_en    = m_run & wr_cfg;
  assign task_address  = {16'h0013, 16'h0012, 16'h0002, 16'h0010};
  assign task_data_out = {16'hA003, 16'hA002, 16'hBEEF, 16'hA000};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;
  int status_writes;
  int start_cnt[NT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step: sample on the falling edge, then scoreboard the memory port.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clock);
    for (int i = 0; i < NT; i++) begin
      if (task_start[i]) start_cnt[i]++;
      if (m_run[i] && wr_cfg[i]) begin
        check("run_pass_wr_en", 32'(mem_wr_en), 32'd1);
        check("run_pass_address", 32'(mem_address), 32'(slot_addr[i]));
        check("run_pass_data", 32'(mem_data_out), 32'(slot_data[i]));
      end
    end
    if (mem_wr_en && mem_address == ST_ADDR) begin
      status_writes++;
      check("status_write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("status_word", 32'(mem_data_out), 32'(e));
      end
    end
  endtask

  // Drives one round starting on a falling edge and checks its outcome.
  task automatic run_round(input logic [NT-1:0] mask, input logic [W-1:0] exp_status,
                           input logic [NT-1:0] exp_started, input int exp_lat,
                           input int restart_at);
    int lat;
    int w0;
    int s0[NT];
    logic seen;
    logic [NT-1:0] started;
    w0 = status_writes;
    for (int i = 0; i < NT; i++) s0[i] = start_cnt[i];
    start = 1'b1;
    task_mask = mask;
    exp_q.push_back(exp_status);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      tick();
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == restart_at) begin
        start = 1'b1;
        task_mask = '1;
      end
      if (lat == restart_at + 1) start = 1'b0;
      seen = done;
    end
    check("round_done_seen", 32'(seen), 32'd1);
    if (exp_lat > 0) check("round_latency", lat, exp_lat);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("status_writes_per_round", status_writes - w0, 32'd1);
    check("flags_after_round", 32'(flags), 32'(exp_status[NT-1:0]));
    for (int i = 0; i < NT; i++) started[i] = (start_cnt[i] != s0[i]);
    check("started_slots", 32'(started), 32'(exp_started));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0;
    int s1;
    int guard;
    tests_run = 0;
    tests_failed = 0;
    status_writes = 0;
    for (int i = 0; i < NT; i++) begin
      start_cnt[i] = 0;
      lat_cfg[i] = 1;
    end
    flag_cfg = '0;
    wr_cfg = '0;
    rst = 1'b1;
    start = 1'b0;
    task_mask = '0;

    repeat (3) tick();
    check("rst_task_clear", 32'(task_clear), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'(ST_ADDR));
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_task_clear", 32'(task_clear), 32'd0);
    check("idle_task_start", 32'(task_start), 32'd0);

    // Empty mask: SCAN, WRSTAT, FIN, then done.
    run_round(4'b0000, 16'h0000, 4'b0000, 4, -1);

    // Slots 0 and 2 only; slot 0 flag=1 after 10 cycles, slot 2 flag=0.
    lat_cfg[0] = 10; lat_cfg[2] = 3;
    flag_cfg = 4'b0001;
    run_round(4'b0101, 16'h0001, 4'b0101, 25, -1);

    // Slot 1 writes to 16'h0002 through the shared port while running.
    lat_cfg[1] = 6;
    flag_cfg = 4'b0010;
    wr_cfg = 4'b0010;
    run_round(4'b0010, 16'h0002, 4'b0010, 14, -1);
    wr_cfg = '0;

    // Second start while busy must be ignored; slot 0 carries a stale done.
    lat_cfg[0] = 5;
    flag_cfg = 4'b0001;
    run_round(4'b0001, 16'h0001, 4'b0001, 13, 3);
    w0 = status_writes;
    repeat (10) tick();
    check("idle_after_ignored_start", 32'(busy), 32'd0);
    check("no_extra_status_write", status_writes - w0, 32'd0);

    // All slots, mixed flags.
    lat_cfg[0] = 1; lat_cfg[1] = 2; lat_cfg[2] = 3; lat_cfg[3] = 4;
    flag_cfg = 4'b1011;
    run_round(4'b1111, 16'h000B, 4'b1111, 30, -1);

    // Reset while slot 1 is running: round aborts with no status write.
    lat_cfg[0] = 2; lat_cfg[1] = 0;
    flag_cfg = 4'b0011;
    w0 = status_writes;
    s1 = start_cnt[1];
    start = 1'b1;
    task_mask = 4'b0011;
    tick();
    start = 1'b0;
    guard = 0;
    while (start_cnt[1] == s1 && guard < 60) begin
      tick();
      guard++;
    end
    check("slot1_started", start_cnt[1] - s1, 32'd1);
    repeat (3) tick();
    check("mid_round_busy", 32'(busy), 32'd1);
    check("mid_round_flags", 32'(flags), 32'h1);
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("abort_task_clear", 32'(task_clear), 32'hF);
    check("abort_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("abort_no_status_write", status_writes - w0, 32'd0);

`ifdef TASK_TIMEOUT_EN
    // Slot 0 hangs: 8 RUN cycles, then its flag is forced 0 and bit 15 is set.
    lat_cfg[0] = 0; lat_cfg[2] = 3;
    flag_cfg = 4'b0101;
    run_round(4'b0101, 16'h8004, 4'b0101, 22, -1);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
`endif

    lat_cfg[0] = 1;
    flag_cfg = 4'b0000;
    run_round(4'b0001, 16'h0000, 4'b0001, 9, -1);
`ifdef TASK_TIMEOUT_EN
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);
`endif

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
